// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : picorv32-style native memory port (valid/ready handshake).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    // master issues requests; slave answers with ready/rdata
    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin two-requester arbiter for one native memory port,
//               one transfer per grant, with a bounded-wait timeout abort.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master s,
    output logic [1:0]    grant,
    output logic          timeout
);
    // TIMEOUT=0 still needs a legal one-bit counter even though it never aborts
    localparam int                  c_WCNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_WCNT_W-1:0] c_WCNT_MAX = c_WCNT_W'(TIMEOUT);
    localparam logic                c_TO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t              r_state;
    logic                r_last;
    logic [c_WCNT_W-1:0] r_wcnt;

    logic w_own0;
    logic w_own1;
    logic w_req_valid;
    logic w_done;
    logic w_abort;
    logic w_release;

    always_comb begin
        w_own0      = (r_state == GNT0);
        w_own1      = (r_state == GNT1);
        w_req_valid = (w_own0 & m0.valid) | (w_own1 & m1.valid);
        w_done      = w_req_valid & s.ready;
        // a completing s_ready in the limit cycle takes priority over the abort
        w_abort     = c_TO_EN & w_req_valid & ~s.ready & (r_wcnt == c_WCNT_MAX);
        w_release   = w_done | w_abort | ~w_req_valid;
    end

    always_comb begin
        s.valid  = 1'b0;
        s.instr  = 1'b0;
        s.addr   = 32'h0;
        s.wdata  = 32'h0;
        s.wstrb  = 4'h0;
        m0.ready = 1'b0;
        m0.rdata = 32'h0;
        m1.ready = 1'b0;
        m1.rdata = 32'h0;
        timeout  = 1'b0;
        if (!reset) begin
            if (w_own0) begin
                s.instr = m0.instr;
                s.addr  = m0.addr;
                s.wdata = m0.wdata;
                s.wstrb = m0.wstrb;
            end else if (w_own1) begin
                s.instr = m1.instr;
                s.addr  = m1.addr;
                s.wdata = m1.wdata;
                s.wstrb = m1.wstrb;
            end
            s.valid  = w_req_valid & ~w_abort;
            m0.ready = w_own0 & (w_done | w_abort);
            m1.ready = w_own1 & (w_done | w_abort);
            if (w_own0 && w_done) begin
                m0.rdata = s.rdata;
            end
            if (w_own1 && w_done) begin
                m1.rdata = s.rdata;
            end
            timeout  = w_abort;
        end
    end

    assign grant = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_wcnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wcnt <= '0;
                    // on a tie the requester that did not own the port last wins
                    if (m0.valid && (!m1.valid || r_last)) begin
                        r_state <= GNT0;
                        r_last  <= 1'b0;
                    end else if (m1.valid) begin
                        r_state <= GNT1;
                        r_last  <= 1'b1;
                    end
                end
                default: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        r_wcnt  <= '0;
                    end else begin
                        r_wcnt  <= r_wcnt + c_WCNT_W'(1);
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed and randomized checks of mem_arbiter against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int c_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant;
    logic       timeout;

    mem_arbiter_if m0_if ();
    mem_arbiter_if m1_if ();
    mem_arbiter_if s_if ();

    mem_arbiter #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk     (clk),
        .reset   (reset),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .grant   (grant),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: owner -1 = nobody, 0/1 = requester; waits = cycles stalled so far
    int mo = -1, mlast = 1, mwait = 0;
    int n_mo, n_last, n_wait;
    logic [1:0]  e_grant;
    logic        e_timeout, e_svalid, e_sinstr;
    logic [31:0] e_saddr, e_swdata;
    logic [3:0]  e_swstrb;
    logic        e_ready [2];
    logic [31:0] e_rdata [2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(int idx, logic v, logic ins, logic [31:0] a, logic [31:0] wd, logic [3:0] ws);
        if (idx == 0) begin
            m0_if.valid = v; m0_if.instr = ins; m0_if.addr = a; m0_if.wdata = wd; m0_if.wstrb = ws;
        end else begin
            m1_if.valid = v; m1_if.instr = ins; m1_if.addr = a; m1_if.wdata = wd; m1_if.wstrb = ws;
        end
    endtask

    task automatic model_eval();
        logic        v [2];
        logic        ins [2];
        logic [31:0] a [2];
        logic [31:0] wd [2];
        logic [3:0]  ws [2];
        logic        done, abort;
        v[0] = m0_if.valid; ins[0] = m0_if.instr; a[0] = m0_if.addr; wd[0] = m0_if.wdata; ws[0] = m0_if.wstrb;
        v[1] = m1_if.valid; ins[1] = m1_if.instr; a[1] = m1_if.addr; wd[1] = m1_if.wdata; ws[1] = m1_if.wstrb;
        e_grant   = (mo < 0) ? 2'b00 : 2'(1 << mo);
        e_timeout = 1'b0; e_svalid = 1'b0; e_sinstr = 1'b0;
        e_saddr   = 32'h0; e_swdata = 32'h0; e_swstrb = 4'h0;
        e_ready[0] = 1'b0; e_ready[1] = 1'b0; e_rdata[0] = 32'h0; e_rdata[1] = 32'h0;
        n_mo = mo; n_last = mlast; n_wait = mwait;
        if (reset) begin
            n_mo = -1; n_last = 1; n_wait = 0;
        end else if (mo < 0) begin
            n_wait = 0;
            if (v[0] && v[1]) n_mo = 1 - mlast;
            else if (v[0])    n_mo = 0;
            else if (v[1])    n_mo = 1;
            if (n_mo >= 0) n_last = n_mo;
        end else begin
            done  = v[mo] && s_if.ready;
            abort = (c_TIMEOUT != 0) && v[mo] && !s_if.ready && (mwait == c_TIMEOUT);
            e_svalid    = v[mo] && !abort;
            e_sinstr    = ins[mo];
            e_saddr     = a[mo];
            e_swdata    = wd[mo];
            e_swstrb    = ws[mo];
            e_ready[mo] = done || abort;
            e_rdata[mo] = done ? s_if.rdata : 32'h0;
            e_timeout   = abort;
            if (done || abort || !v[mo]) begin
                n_mo = -1; n_wait = 0;
            end else begin
                n_wait = mwait + 1;
            end
        end
    endtask

    task automatic compare_all(string tag);
        chk({tag, ".grant"},    32'(grant),        32'(e_grant));
        chk({tag, ".timeout"},  32'(timeout),      32'(e_timeout));
        chk({tag, ".s_valid"},  32'(s_if.valid),   32'(e_svalid));
        chk({tag, ".s_instr"},  32'(s_if.instr),   32'(e_sinstr));
        chk({tag, ".s_addr"},   s_if.addr,         e_saddr);
        chk({tag, ".s_wdata"},  s_if.wdata,        e_swdata);
        chk({tag, ".s_wstrb"},  32'(s_if.wstrb),   32'(e_swstrb));
        chk({tag, ".m0_ready"}, 32'(m0_if.ready),  32'(e_ready[0]));
        chk({tag, ".m1_ready"}, 32'(m1_if.ready),  32'(e_ready[1]));
        chk({tag, ".m0_rdata"}, m0_if.rdata,       e_rdata[0]);
        chk({tag, ".m1_rdata"}, m1_if.rdata,       e_rdata[1]);
    endtask

    // inputs are driven at posedge+1; outputs are sampled one unit later
    task automatic settle(string tag);
        #1;
        model_eval();
        compare_all(tag);
    endtask

    task automatic advance();
        @(posedge clk);
        mo = n_mo; mlast = n_last; mwait = n_wait;
        #1;
    endtask

    task automatic tick(string tag);
        settle(tag);
        advance();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [1:0] rr_exp [8];
        logic       cur_v;

        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        s_if.ready = 1'b0;
        s_if.rdata = 32'h0;
        @(posedge clk); #1;

        // reset held two cycles with both requesters asking
        for (int i = 0; i < 2; i++) begin
            settle("reset");
            chk("reset.grant_zero", 32'(grant), 32'h0);
            chk("reset.s_valid_zero", 32'(s_if.valid), 32'h0);
            advance();
        end
        reset = 1'b0;
        settle("release");
        chk("release.idle", 32'(grant), 32'h0);
        advance();
        settle("release.g");
        chk("release.grant_m0", 32'(grant), 32'h1);
        advance();
        s_if.ready = 1'b1; s_if.rdata = 32'h1111_1111;
        settle("release.done");
        chk("release.m0_ready", 32'(m0_if.ready), 32'h1);
        advance();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        s_if.ready = 1'b0;
        tick("idle0");

        // single read, s_ready two cycles after s_valid
        drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        tick("rd.req");
        settle("rd.g");
        chk("rd.s_valid", 32'(s_if.valid), 32'h1);
        chk("rd.s_addr", s_if.addr, 32'h100);
        advance();
        tick("rd.wait");
        s_if.ready = 1'b1; s_if.rdata = 32'hDEAD_BEEF;
        settle("rd.done");
        chk("rd.m0_ready", 32'(m0_if.ready), 32'h1);
        chk("rd.m0_rdata", m0_if.rdata, 32'hDEAD_BEEF);
        chk("rd.m1_ready", 32'(m1_if.ready), 32'h0);
        advance();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        s_if.ready = 1'b0;
        settle("rd.after");
        chk("rd.one_cycle_ready", 32'(m0_if.ready), 32'h0);
        advance();

        // round robin with both requesters always valid
        reset = 1'b1;
        tick("rr.rst");
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b1, 32'h600, 32'h0, 4'h0);
        s_if.ready = 1'b1;
        rr_exp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        for (int i = 0; i < 8; i++) begin
            s_if.rdata = 32'hA5A5_0000 + 32'(i);
            settle("rr");
            chk("rr.grant_seq", 32'(grant), 32'(rr_exp[i]));
            advance();
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        s_if.ready = 1'b0;
        tick("rr.idle");

        // timeout abort on m1
        drive(1, 1'b1, 1'b1, 32'h200, 32'h0, 4'h0);
        s_if.rdata = 32'hCAFE_F00D;
        tick("to.req");
        for (int i = 0; i < c_TIMEOUT; i++) begin
            settle("to.wait");
            chk("to.wait_no_timeout", 32'(timeout), 32'h0);
            chk("to.wait_s_valid", 32'(s_if.valid), 32'h1);
            advance();
        end
        settle("to.abort");
        chk("to.m1_ready", 32'(m1_if.ready), 32'h1);
        chk("to.m1_rdata", m1_if.rdata, 32'h0);
        chk("to.timeout", 32'(timeout), 32'h1);
        chk("to.s_valid_forced", 32'(s_if.valid), 32'h0);
        advance();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle("to.after");
        chk("to.idle", 32'(grant), 32'h0);
        advance();

        // s_ready arrives exactly in the limit cycle
        drive(0, 1'b1, 1'b0, 32'h300, 32'h55, 4'hF);
        tick("sim.req");
        for (int i = 0; i < c_TIMEOUT; i++) tick("sim.wait");
        s_if.ready = 1'b1; s_if.rdata = 32'h1234_5678;
        settle("sim.done");
        chk("sim.m0_ready", 32'(m0_if.ready), 32'h1);
        chk("sim.m0_rdata", m0_if.rdata, 32'h1234_5678);
        chk("sim.no_timeout", 32'(timeout), 32'h0);
        advance();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        s_if.ready = 1'b0;
        tick("sim.idle");

        // owner drops valid while granted
        drive(1, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
        tick("drop.req");
        tick("drop.g");
        drive(1, 1'b0, 1'b0, 32'h400, 32'h0, 4'h0);
        s_if.ready = 1'b1;
        settle("drop.cycle");
        chk("drop.no_ready", 32'(m1_if.ready), 32'h0);
        chk("drop.s_valid", 32'(s_if.valid), 32'h0);
        advance();
        s_if.ready = 1'b0;
        settle("drop.after");
        chk("drop.idle", 32'(grant), 32'h0);
        advance();

        // reset in the middle of an m0 wait; m0 must still win the next tie
        drive(0, 1'b1, 1'b0, 32'h700, 32'h0, 4'h0);
        tick("rst.req");
        tick("rst.w1");
        tick("rst.w2");
        reset = 1'b1;
        drive(1, 1'b1, 1'b0, 32'h800, 32'h0, 4'h0);
        settle("rst.cycle");
        chk("rst.s_valid_drop", 32'(s_if.valid), 32'h0);
        chk("rst.no_ready", 32'(m0_if.ready), 32'h0);
        advance();
        reset = 1'b0;
        settle("rst.rel");
        chk("rst.idle", 32'(grant), 32'h0);
        advance();
        settle("rst.tie");
        chk("rst.m0_wins_tie", 32'(grant), 32'h1);
        advance();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick("rst.idle");

        // randomized traffic; requesters hold payload until ready except rare drops
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                cur_v = (r == 0) ? m0_if.valid : m1_if.valid;
                if (!cur_v || e_ready[r]) begin
                    if ($urandom_range(2) == 0)
                        drive(r, 1'b1, 1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15)));
                    else
                        drive(r, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
                end else if ($urandom_range(19) == 0) begin
                    drive(r, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
                end
            end
            s_if.ready = ($urandom_range(3) == 0);
            s_if.rdata = $urandom;
            reset      = ($urandom_range(99) == 0);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
